// File: rtl/step_dir_pkg.sv
// Shared definitions for the step/direction receive decoder:
// FSM state encoding, readback addresses and direction polarity.
package step_dir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam logic [3:0] RA_STATUS     = 4'd0;
  localparam logic [3:0] RA_POSITION   = 4'd1;
  localparam logic [3:0] RA_STEP_COUNT = 4'd2;
  localparam logic [3:0] RA_PERIOD     = 4'd3;
  localparam logic [3:0] RA_INTERVAL   = 4'd4;
  localparam logic [3:0] RA_PINS       = 4'd5;

  localparam logic DIR_INC = 1'b1;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall
// detection against the previous synchronized value.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // synchronizer shift chain and previous-value flop
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/step_dir_decoder.sv
// Step/direction receive decoder: synchronizes step/dir, tracks position and
// step count, measures step period and flags pulse-width/setup/wrap errors.
module step_dir_decoder #(
  parameter int SYNC_STAGES  = 2,
  parameter int POS_WIDTH    = 32,
  parameter int PERIOD_WIDTH = 24,
  parameter int MIN_PULSE    = 2,
  parameter int DIR_SETUP    = 2
) (
  input  logic                    clk_i,
  input  logic                    reset,
  input  logic                    step_i,
  input  logic                    dir_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic [3:0]              raddr_i,
  output logic [31:0]             rdata,
  output logic [POS_WIDTH-1:0]    position,
  output logic                    step_strobe,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    pw_err,
  output logic                    setup_err,
  output logic                    wrap_err
);
  import step_dir_pkg::*;

  localparam int HC_W = (MIN_PULSE > 0) ? $clog2(MIN_PULSE + 1) : 1;
  localparam int DC_W = (DIR_SETUP > 0) ? $clog2(DIR_SETUP + 1) : 1;
  localparam logic [PERIOD_WIDTH-1:0] IC_MAX  = {PERIOD_WIDTH{1'b1}};
  localparam logic [POS_WIDTH-1:0]    POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic [POS_WIDTH-1:0]    POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};

  logic s_step, s_dir, step_rise, step_fall, dir_rise, dir_fall;
  logic counted, dir_edge, inc, setup_short;
  state_t state, next_state;
  logic [POS_WIDTH-1:0]    step_count;
  logic [PERIOD_WIDTH-1:0] ic;
  logic [HC_W-1:0]         hc;
  logic [DC_W-1:0]         dc;

  sync_edge #(.STAGES(SYNC_STAGES)) u_step_sync (
    .clk(clk_i), .reset(reset), .din(step_i),
    .sync(s_step), .rise(step_rise), .fall(step_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_dir_sync (
    .clk(clk_i), .reset(reset), .din(dir_i),
    .sync(s_dir), .rise(dir_rise), .fall(dir_fall)
  );

  assign counted     = step_rise & enable_i & ~clear_i;
  assign dir_edge    = dir_rise | dir_fall;
  assign inc         = (s_dir == DIR_INC);
  // a dir change seen in the same cycle as the rise counts as zero setup
  assign setup_short = dir_edge | (dc < DC_W'(DIR_SETUP));

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    if (clear_i) begin
      next_state = ST_IDLE;
    end else if (!enable_i) begin
      next_state = state;
    end else begin
      case (state)
        ST_IDLE:  next_state = counted ? ST_TRACK : ST_IDLE;
        ST_TRACK: begin
          if (counted) begin
            next_state = ST_TRACK;
          end else if (ic == IC_MAX) begin
            next_state = ST_STALL;
          end else begin
            next_state = ST_TRACK;
          end
        end
        ST_STALL: next_state = counted ? ST_TRACK : ST_STALL;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // position, step count, interval timer, period and sticky flags
  always_ff @(posedge clk_i) begin
    if (reset || clear_i) begin
      position     <= '0;
      step_count   <= '0;
      ic           <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      step_strobe  <= 1'b0;
      pw_err       <= 1'b0;
      setup_err    <= 1'b0;
      wrap_err     <= 1'b0;
    end else begin
      step_strobe <= counted;
      if (counted) begin
        position   <= inc ? position + POS_WIDTH'(1'b1) : position - POS_WIDTH'(1'b1);
        step_count <= step_count + POS_WIDTH'(1'b1);
        if ((inc && position == POS_MAX) || (!inc && position == POS_MIN)) begin
          wrap_err <= 1'b1;
        end
        if (setup_short) begin
          setup_err <= 1'b1;
        end
      end
      if (counted) begin
        ic <= '0;
      end else if (enable_i && ic != IC_MAX) begin
        ic <= ic + PERIOD_WIDTH'(1'b1);
      end
      // TRACK measures on each step; a saturated timer invalidates it
      if (counted && state == ST_TRACK) begin
        period       <= (ic == IC_MAX) ? IC_MAX : ic + PERIOD_WIDTH'(1'b1);
        period_valid <= 1'b1;
      end else if (enable_i && state == ST_TRACK && ic == IC_MAX) begin
        period_valid <= 1'b0;
      end
      if (step_fall && hc < HC_W'(MIN_PULSE)) begin
        pw_err <= 1'b1;
      end
    end
  end

  // high-time and dir-stable counters; deliberately untouched by clear_i
  always_ff @(posedge clk_i) begin
    if (reset) begin
      hc <= '0;
      dc <= '0;
    end else begin
      if (!s_step) begin
        hc <= '0;
      end else if (hc < HC_W'(MIN_PULSE)) begin
        hc <= hc + HC_W'(1'b1);
      end
      if (dir_edge) begin
        dc <= '0;
      end else if (dc < DC_W'(DIR_SETUP)) begin
        dc <= dc + DC_W'(1'b1);
      end
    end
  end

  // registered readback mux
  always_ff @(posedge clk_i) begin
    if (reset) begin
      rdata <= 32'd0;
    end else begin
      case (raddr_i)
        RA_STATUS:     rdata <= {27'd0, state, wrap_err, setup_err, pw_err};
        RA_POSITION:   rdata <= 32'(position);
        RA_STEP_COUNT: rdata <= 32'(step_count);
        RA_PERIOD:     rdata <= 32'(period);
        RA_INTERVAL:   rdata <= 32'(ic);
        RA_PINS:       rdata <= {30'd0, s_dir, s_step};
        default:       rdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed, table-driven bench for step_dir_decoder: a default-sized instance
// plus a narrow one (4-bit position, 8-bit period) for wrap and stall cases.
module tb_step_dir_decoder;

  logic        clk = 1'b0;
  logic        reset, step_i, dir_i, enable_i, clear_i;
  logic [3:0]  raddr_i;

  logic [31:0] rdata, position;
  logic [23:0] period;
  logic        step_strobe, period_valid, pw_err, setup_err, wrap_err;

  logic [31:0] s_rdata;
  logic [3:0]  s_position;
  logic [7:0]  s_period;
  logic        s_step_strobe, s_period_valid, s_pw_err, s_setup_err, s_wrap_err;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  int snap;

  always #5 clk = ~clk;

  step_dir_decoder dut (
    .clk_i(clk), .reset(reset), .step_i(step_i), .dir_i(dir_i),
    .enable_i(enable_i), .clear_i(clear_i), .raddr_i(raddr_i),
    .rdata(rdata), .position(position), .step_strobe(step_strobe),
    .period(period), .period_valid(period_valid),
    .pw_err(pw_err), .setup_err(setup_err), .wrap_err(wrap_err)
  );

  step_dir_decoder #(.POS_WIDTH(4), .PERIOD_WIDTH(8)) dut_small (
    .clk_i(clk), .reset(reset), .step_i(step_i), .dir_i(dir_i),
    .enable_i(enable_i), .clear_i(clear_i), .raddr_i(raddr_i),
    .rdata(s_rdata), .position(s_position), .step_strobe(s_step_strobe),
    .period(s_period), .period_valid(s_period_valid),
    .pw_err(s_pw_err), .setup_err(s_setup_err), .wrap_err(s_wrap_err)
  );

  always @(negedge clk) begin
    if (step_strobe === 1'b1) strobes = strobes + 1;
  end

  typedef struct {
    logic        clr;
    logic        dir;
    int          pre;
    int          hi;
    int          lo;
    logic [31:0] pos;
    logic        valid;
    logic [23:0] per;
    logic        pw;
    logic        setup;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp;
  } rb_t;

  vec_t vecs [0:9];
  rb_t  rbs  [0:7];

  function automatic vec_t mk(input logic clr, input logic dir, input int pre,
                              input int hi, input int lo, input logic [31:0] pos,
                              input logic valid, input logic [23:0] per,
                              input logic pw, input logic setup);
    vec_t v;
    v.clr = clr; v.dir = dir; v.pre = pre; v.hi = hi; v.lo = lo;
    v.pos = pos; v.valid = valid; v.per = per; v.pw = pw; v.setup = setup;
    return v;
  endfunction

  function automatic rb_t mkr(input logic [3:0] a, input logic [31:0] e);
    rb_t r;
    r.addr = a; r.exp = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic d, input int pre, input int hi, input int lo);
    dir_i = d;
    tick(pre);
    step_i = 1'b1;
    tick(hi);
    step_i = 1'b0;
    tick(lo);
  endtask

  task automatic clear_pulse();
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
  endtask

  initial begin
    //        clr   dir   pre hi lo  position       valid  period  pw    setup
    vecs[0] = mk(1'b0, 1'b1, 5, 4, 6, 32'd1,          1'b0, 24'd0,  1'b0, 1'b0);
    vecs[1] = mk(1'b0, 1'b1, 0, 4, 6, 32'd2,          1'b1, 24'd10, 1'b0, 1'b0);
    vecs[2] = mk(1'b0, 1'b1, 0, 4, 6, 32'd3,          1'b1, 24'd10, 1'b0, 1'b0);
    vecs[3] = mk(1'b0, 1'b1, 0, 4, 6, 32'd4,          1'b1, 24'd10, 1'b0, 1'b0);
    vecs[4] = mk(1'b0, 1'b1, 0, 4, 6, 32'd5,          1'b1, 24'd10, 1'b0, 1'b0);
    vecs[5] = mk(1'b1, 1'b0, 5, 4, 6, 32'hFFFF_FFFF,  1'b0, 24'd0,  1'b0, 1'b0);
    vecs[6] = mk(1'b0, 1'b0, 0, 4, 6, 32'hFFFF_FFFE,  1'b1, 24'd10, 1'b0, 1'b0);
    vecs[7] = mk(1'b0, 1'b0, 0, 4, 6, 32'hFFFF_FFFD,  1'b1, 24'd10, 1'b0, 1'b0);
    // dir flips one synced cycle ahead of the rise: setup error, new dir used
    vecs[8] = mk(1'b0, 1'b1, 1, 4, 6, 32'hFFFF_FFFE,  1'b1, 24'd11, 1'b0, 1'b1);
    // single-cycle high pulse: counted but flagged
    vecs[9] = mk(1'b0, 1'b1, 0, 1, 9, 32'hFFFF_FFFF,  1'b1, 24'd10, 1'b1, 1'b1);

    rbs[0] = mkr(4'd0,  32'h0000_000B);
    rbs[1] = mkr(4'd1,  32'hFFFF_FFFF);
    rbs[2] = mkr(4'd2,  32'd5);
    rbs[3] = mkr(4'd3,  32'd10);
    rbs[4] = mkr(4'd4,  32'd7);
    rbs[5] = mkr(4'd5,  32'h0000_0002);
    rbs[6] = mkr(4'd6,  32'd0);
    rbs[7] = mkr(4'd15, 32'd0);

    reset = 1'b1; step_i = 1'b0; dir_i = 1'b0; enable_i = 1'b0;
    clear_i = 1'b0; raddr_i = 4'd0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset position", position, 32'd0);
    check("reset period", 32'(period), 32'd0);
    check("reset period_valid", 32'(period_valid), 32'd0);
    check("reset errors", {29'd0, wrap_err, setup_err, pw_err}, 32'd0);
    check("reset strobe", 32'(step_strobe), 32'd0);
    check("reset rdata", rdata, 32'd0);

    enable_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].clr) clear_pulse();
      pulse(vecs[i].dir, vecs[i].pre, vecs[i].hi, vecs[i].lo);
      check($sformatf("row%0d position", i), position, vecs[i].pos);
      check($sformatf("row%0d period_valid", i), 32'(period_valid), 32'(vecs[i].valid));
      check($sformatf("row%0d period", i), 32'(period), 32'(vecs[i].per));
      check($sformatf("row%0d pw_err", i), 32'(pw_err), 32'(vecs[i].pw));
      check($sformatf("row%0d setup_err", i), 32'(setup_err), 32'(vecs[i].setup));
    end
    check("strobe total", strobes, 32'd10);
    check("wrap_err clean", 32'(wrap_err), 32'd0);

    // freeze counting so the interval timer holds still during readback
    enable_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr_i = rbs[i].addr;
      tick(1);
      check($sformatf("readback addr %0d", rbs[i].addr), rdata, rbs[i].exp);
    end

    // clear lands on the cycle the synced rise appears: edge is dropped
    enable_i = 1'b1;
    raddr_i  = 4'd0;
    snap     = strobes;
    step_i   = 1'b1;
    tick(2);
    clear_i  = 1'b1;
    tick(1);
    clear_i  = 1'b0;
    tick(4);
    check("clear+rise position", position, 32'd0);
    check("clear+rise strobes", strobes, snap);
    check("clear+rise status", rdata, 32'd0);
    step_i = 1'b0;
    tick(6);
    pulse(1'b1, 0, 4, 6);
    check("after clear position", position, 32'd1);
    check("after clear strobes", strobes, snap + 1);
    check("after clear status", rdata, 32'h0000_0008);

    // narrow instance: timer saturation drives TRACK -> STALL
    clear_pulse();
    pulse(1'b1, 0, 4, 6);
    tick(300);
    check("stall status", s_rdata, 32'h0000_0010);
    check("stall period_valid", 32'(s_period_valid), 32'd0);
    pulse(1'b1, 0, 4, 16);
    check("restart period_valid", 32'(s_period_valid), 32'd0);
    check("restart period held", 32'(s_period), 32'd0);
    pulse(1'b1, 0, 4, 16);
    check("restart period", 32'(s_period), 32'd20);
    check("restart period_valid set", 32'(s_period_valid), 32'd1);

    // narrow instance: signed wrap 7 -> -8
    clear_pulse();
    for (int i = 0; i < 7; i++) pulse(1'b1, 0, 2, 2);
    check("pre-wrap position", 32'(s_position), 32'd7);
    check("pre-wrap wrap_err", 32'(s_wrap_err), 32'd0);
    pulse(1'b1, 0, 2, 2);
    check("wrap position", 32'(s_position), 32'd8);
    check("wrap wrap_err", 32'(s_wrap_err), 32'd1);
    tick(1);
    check("wrap status", s_rdata, 32'h0000_000C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
